// File: rtl/tcm_pkg.sv
// Shared types and widths for the TCM bus adapter and its response FIFO.
package tcm_pkg;

    localparam int unsigned TCM_DATA_W = 32;
    localparam int unsigned TCM_ADDR_W = 15;
    localparam int unsigned TCM_BE_W   = TCM_DATA_W / 8;
    localparam int unsigned TCM_OFS_W  = $clog2(TCM_BE_W);

    typedef struct packed {
        logic                  err;
        logic [TCM_DATA_W-1:0] rdata;
    } tcm_rsp_t;

endpackage

// File: rtl/tcm_rsp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH, push and pop may coincide
// even when full because the caller's credit counter already reserved the slot.
module tcm_rsp_fifo
    import tcm_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  tcm_rsp_t                     push_data_i,
    input  logic                         pop_i,
    output tcm_rsp_t                     head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    tcm_rsp_t           mem_q [DEPTH];
    tcm_rsp_t           mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/tcm_bus_adapter.sv
// Valid/ready front end for the banked TCM: issues single-cycle SRAM strobes,
// absorbs the 1-cycle read latency and buffers responses in request order.
module tcm_bus_adapter
    import tcm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TCM_DATA_W,
    parameter int unsigned ADDR_WIDTH = TCM_ADDR_W,
    parameter int unsigned RSP_DEPTH  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    tcm_en_o,
    output logic                    tcm_we_o,
    output logic [DATA_WIDTH/8-1:0] tcm_be_o,
    output logic [ADDR_WIDTH-1:0]   tcm_addr_o,
    output logic [DATA_WIDTH-1:0]   tcm_wdata_o,
    input  logic [DATA_WIDTH-1:0]   tcm_rdata_i
);

    localparam int unsigned OFS_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic             accept;
    logic             aligned;
    logic             pop;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_is_read_q, s1_is_read_d;
    logic             s1_err_q, s1_err_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    tcm_rsp_t         push_data;
    tcm_rsp_t         head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_fifo_status;

    assign aligned     = (req_addr_i[OFS_W-1:0] == '0);
    assign req_ready_o = ~rst_i & (occ_q < CNT_W'(RSP_DEPTH));
    assign accept      = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_o & rsp_ready_i;

    always_comb begin
        tcm_en_o    = accept & aligned;
        tcm_we_o    = tcm_en_o & req_we_i;
        tcm_be_o    = tcm_en_o ? req_be_i : '0;
        tcm_wdata_o = tcm_en_o ? req_wdata_i : '0;
        tcm_addr_o  = tcm_en_o ? {req_addr_i[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}} : '0;
    end

    // Occupancy covers stage 1 plus the FIFO, so it reaching RSP_DEPTH is what
    // guarantees the push a cycle later always finds a free slot.
    always_comb begin
        s1_valid_d   = accept;
        s1_is_read_d = accept & ~req_we_i;
        s1_err_d     = accept & ~aligned;
        occ_d        = occ_q + CNT_W'(accept) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_is_read_q <= 1'b0;
            s1_err_q     <= 1'b0;
            occ_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_is_read_q <= s1_is_read_d;
            s1_err_q     <= s1_err_d;
            occ_q        <= occ_d;
        end
    end

    always_comb begin
        push_data.err   = s1_err_q;
        push_data.rdata = (s1_is_read_q & ~s1_err_q) ? tcm_rdata_i : '0;
    end

    tcm_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (s1_valid_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign unused_fifo_status = ^{fifo_full, fifo_count};

    assign rsp_valid_o = ~fifo_empty;
    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
    assign rsp_err_o   = rsp_valid_o & head.err;

endmodule

// File: tb/tb_tcm_bus_adapter.sv
// Self-checking bench: SRAM environment model plus a transaction-level reference
// (expected-response queue with due cycles, shadow memory, credit count).
module tb_tcm_bus_adapter;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [14:0] req_addr_i;
    logic        req_we_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        tcm_en_o;
    logic        tcm_we_o;
    logic [3:0]  tcm_be_o;
    logic [14:0] tcm_addr_o;
    logic [31:0] tcm_wdata_o;
    logic [31:0] tcm_rdata_i;

    tcm_bus_adapter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(15),
        .RSP_DEPTH (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .tcm_en_o    (tcm_en_o),
        .tcm_we_o    (tcm_we_o),
        .tcm_be_o    (tcm_be_o),
        .tcm_addr_o  (tcm_addr_o),
        .tcm_wdata_o (tcm_wdata_o),
        .tcm_rdata_i (tcm_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SRAM environment: 1-cycle read latency, read data scrambled when idle.
    logic [31:0] sram    [0:8191];
    logic [31:0] ref_mem [0:8191];
    logic [31:0] sram_rdata;
    assign tcm_rdata_i = sram_rdata;

    always @(posedge clk_i) begin
        if (tcm_en_o && tcm_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (tcm_be_o[b]) sram[tcm_addr_o[14:2]][8*b +: 8] = tcm_wdata_o[8*b +: 8];
            end
            sram_rdata <= $urandom;
        end else if (tcm_en_o) begin
            sram_rdata <= sram[tcm_addr_o[14:2]];
        end else begin
            sram_rdata <= $urandom;
        end
    end

    // Reference model
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          outstanding = 0;
    int          pops = 0;
    int          err_pops = 0;
    logic [31:0] last_pop_rdata = '0;

    always @(negedge clk_i) begin
        logic acc, pop, al, exp_valid;
        exp_t e;
        cyc++;
        if (rst_i) begin
            check_eq("rst_rsp_valid", rsp_valid_o, 0);
            check_eq("rst_rsp_rdata", rsp_rdata_o, 0);
            check_eq("rst_rsp_err", rsp_err_o, 0);
            check_eq("rst_req_ready", req_ready_o, 0);
            check_eq("rst_tcm_en", tcm_en_o, 0);
            exp_q.delete();
            outstanding = 0;
        end else begin
            acc = req_valid_i & req_ready_o;
            pop = rsp_valid_o & rsp_ready_i;
            al  = (req_addr_i[1:0] == 2'b00);
            check_eq("req_ready", req_ready_o, outstanding < 3);
            check_eq("tcm_en", tcm_en_o, acc & al);
            if (acc & al) begin
                check_eq("tcm_we", tcm_we_o, req_we_i);
                check_eq("tcm_addr", tcm_addr_o, {req_addr_i[14:2], 2'b00});
                if (req_we_i) begin
                    check_eq("tcm_be", tcm_be_o, req_be_i);
                    check_eq("tcm_wdata", tcm_wdata_o, req_wdata_i);
                end
            end else begin
                check_eq("tcm_we_idle", tcm_we_o, 0);
            end
            exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            check_eq("rsp_valid", rsp_valid_o, exp_valid);
            if (exp_valid) begin
                check_eq("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
                check_eq("rsp_err", rsp_err_o, exp_q[0].err);
            end
            if (pop && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_pop_rdata = e.rdata;
                pops++;
                if (e.err) err_pops++;
            end
            if (acc) begin
                e.due = cyc + 2;
                if (!al) begin
                    e.err = 1'b1;
                    e.rdata = '0;
                end else if (req_we_i) begin
                    e.err = 1'b0;
                    e.rdata = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (req_be_i[b]) ref_mem[req_addr_i[14:2]][8*b +: 8] = req_wdata_i[8*b +: 8];
                    end
                end else begin
                    e.err = 1'b0;
                    e.rdata = ref_mem[req_addr_i[14:2]];
                end
                exp_q.push_back(e);
            end
            outstanding = outstanding + (acc ? 1 : 0) - ((pop && outstanding > 0) ? 1 : 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_req(input logic we, input logic [14:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        logic acc;
        int   n;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_be_i    = be;
        req_wdata_i = wd;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk_i);
            acc = req_ready_o;
            n++;
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        check_eq("req_accepted", acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int          p0, e0, c0, accepts;
        logic        acc;
        logic [31:0] v;

        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_we_i    = 1'b0;
        req_be_i    = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            v = $urandom;
            sram[i] = v;
            ref_mem[i] = v;
        end
        sram[4] = 32'hDEADBEEF;  ref_mem[4] = 32'hDEADBEEF;
        sram[8] = 32'hFFFFFFFF;  ref_mem[8] = 32'hFFFFFFFF;
        #2 rst_i = 1'b1;
        #1;
        check_eq("rst_ready_immediate", req_ready_o, 0);
        idle(3);
        rst_i = 1'b0;
        idle(1);

        // Single read of 0x0010
        p0 = pops;
        do_req(1'b0, 15'h0010, 4'h0, 32'h0);
        idle(3);
        check_eq("rd1_pops", pops - p0, 1);
        check_eq("rd1_data", last_pop_rdata, 32'hDEADBEEF);

        // Partial write then read back of 0x0020
        p0 = pops;
        do_req(1'b1, 15'h0020, 4'b0011, 32'h12345678);
        do_req(1'b0, 15'h0020, 4'h0, 32'h0);
        idle(3);
        check_eq("wr_rd_pops", pops - p0, 2);
        check_eq("wr_rd_data", last_pop_rdata, 32'hFFFF5678);

        // Back-to-back reads, one accept per cycle
        c0 = cyc;
        for (int i = 0; i < 4; i++) do_req(1'b0, 15'(i * 4), 4'h0, 32'h0);
        check_eq("b2b_cycles", cyc - c0, 4);
        idle(4);

        // Stall: only three requests fit
        rsp_ready_i = 1'b0;
        v = ref_mem[16];
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 15'h0040;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            acc = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) begin
                accepts++;
                req_addr_i = req_addr_i + 15'd4;
            end
        end
        req_valid_i = 1'b0;
        check_eq("stall_accepts", accepts, 3);
        check_eq("stall_ready_low", req_ready_o, 0);
        check_eq("stall_hold_rdata", rsp_rdata_o, v);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("stall_ready_pop_cycle", req_ready_o, 0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check_eq("stall_ready_after_pop", req_ready_o, 1);
        idle(4);

        // Misaligned access between aligned neighbours
        e0 = err_pops;
        do_req(1'b0, 15'h0000, 4'h0, 32'h0);
        do_req(1'b0, 15'h0006, 4'h0, 32'h0);
        do_req(1'b0, 15'h0008, 4'h0, 32'h0);
        idle(4);
        check_eq("misalign_err_count", err_pops - e0, 1);

        // Reset with two buffered responses and one read in flight
        rsp_ready_i = 1'b0;
        do_req(1'b0, 15'h0100, 4'h0, 32'h0);
        do_req(1'b0, 15'h0104, 4'h0, 32'h0);
        do_req(1'b0, 15'h0108, 4'h0, 32'h0);
        check_eq("prerst_valid", rsp_valid_o, 1);
        rst_i = 1'b1;
        #1;
        check_eq("rst_now_valid", rsp_valid_o, 0);
        check_eq("rst_now_rdata", rsp_rdata_o, 0);
        check_eq("rst_now_ready", req_ready_o, 0);
        idle(2);
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        p0 = pops;
        idle(6);
        check_eq("rst_no_stale", pops - p0, 0);
        check_eq("rst_ready_after", req_ready_o, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            acc = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #1;
            if (!req_valid_i || acc) begin
                req_valid_i = ($urandom_range(0, 3) != 0);
                req_we_i    = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 4) == 0) req_addr_i = 15'($urandom_range(0, 63));
                else                           req_addr_i = 15'($urandom_range(0, 15) * 4);
                req_be_i    = 4'($urandom);
                req_wdata_i = $urandom;
            end
            rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        idle(10);
        check_eq("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
